// File: rtl/bit_packer.sv
// Packs 0..IN_W-bit fields into OUT_W-bit words (first bit at bit 0, or at OUT_W-1 when MSB_FIRST); in_last flushes a partial word.
// A word completed on accept is presented the next cycle; a pending word holds stable and blocks input until consumed.
module bit_packer #(
  parameter int IN_W      = 8,
  parameter int OUT_W     = 16,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [IN_W-1:0]            in_data,
  input  logic [$clog2(IN_W+1)-1:0]  in_len,
  input  logic                       in_last,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [OUT_W-1:0]           out_data,
  output logic [$clog2(OUT_W+1)-1:0] out_nbits,
  output logic                       out_last
);
  localparam int LEN_W  = $clog2(IN_W + 1);
  localparam int NB_W   = $clog2(OUT_W + 1);
  localparam int ACC_W  = OUT_W + IN_W - 1;
  localparam int FILL_W = $clog2(ACC_W + 1);
  localparam logic [LEN_W-1:0]  LEN_MAX   = LEN_W'(IN_W);
  localparam logic [FILL_W-1:0] FILL_WORD = FILL_W'(OUT_W);

  // acc_q always holds the stream in arrival order: stream bit 0 sits at acc_q[0],
  // and every bit at or above fill_q is zero.
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic              flush_pend_q, flush_pend_d;

  logic [LEN_W-1:0]  len;
  logic [IN_W-1:0]   fld_mask;
  logic [IN_W-1:0]   fld_rev;
  logic [IN_W-1:0]   fld;
  logic [ACC_W-1:0]  fld_ext;
  logic [FILL_W-1:0] emit_n;
  logic [OUT_W-1:0]  word;
  logic              word_full;
  logic              accept;
  logic              emit;

  // Field alignment: MSB-first fields are bit-reversed so in_data[len-1] lands first.
  always_comb begin
    len      = (in_len > LEN_MAX) ? LEN_MAX : in_len;
    fld_mask = (IN_W'(1) << len) - IN_W'(1);
    for (int i = 0; i < IN_W; i++) begin
      fld_rev[i] = in_data[IN_W-1-i];
    end
    if (MSB_FIRST) begin
      fld = fld_rev >> (LEN_MAX - len);
    end else begin
      fld = in_data & fld_mask;
    end
    fld_ext = ACC_W'(fld);
  end

  always_comb begin
    word_full = (fill_q >= FILL_WORD);
    emit_n    = word_full ? FILL_WORD : fill_q;
    in_ready  = !word_full && !flush_pend_q;
    out_valid = word_full || (flush_pend_q && (fill_q != '0));
    word      = acc_q[OUT_W-1:0];
    out_data  = '0;
    out_nbits = '0;
    out_last  = 1'b0;
    if (out_valid) begin
      for (int p = 0; p < OUT_W; p++) begin
        out_data[p] = MSB_FIRST ? word[OUT_W-1-p] : word[p];
      end
      out_nbits = NB_W'(emit_n);
      out_last  = flush_pend_q && (fill_q <= FILL_WORD);
    end
  end

  always_comb begin
    accept       = in_valid && in_ready;
    emit         = out_valid && out_ready;
    acc_d        = acc_q;
    fill_d       = fill_q;
    flush_pend_d = flush_pend_q;
    if (accept) begin
      acc_d  = acc_q | (fld_ext << fill_q);
      fill_d = fill_q + FILL_W'(len);
      if (in_last) begin
        flush_pend_d = 1'b1;
      end
    end else if (emit) begin
      acc_d  = acc_q >> emit_n;
      fill_d = fill_q - emit_n;
      if (out_last) begin
        flush_pend_d = 1'b0;
      end
    end else if (flush_pend_q && (fill_q == '0)) begin
      // Packet ended exactly on a word boundary (or was empty): nothing to emit.
      flush_pend_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q        <= '0;
      fill_q       <= '0;
      flush_pend_q <= 1'b0;
    end else begin
      acc_q        <= acc_d;
      fill_q       <= fill_d;
      flush_pend_q <= flush_pend_d;
    end
  end

endmodule

// File: tb/tb_bit_packer.sv
// Bench for bit_packer: one LSB-first and one MSB-first instance, a bit-stream model and literal word checks.
module tb_bit_packer;
  localparam int IN_W  = 8;
  localparam int OUT_W = 16;
  localparam int LEN_W = $clog2(IN_W + 1);
  localparam int NB_W  = $clog2(OUT_W + 1);

  typedef struct packed {
    logic [OUT_W-1:0] data;
    logic [NB_W-1:0]  nbits;
    logic             last;
  } word_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid  [2];
  logic             in_ready  [2];
  logic [IN_W-1:0]  in_data   [2];
  logic [LEN_W-1:0] in_len    [2];
  logic             in_last   [2];
  logic             out_valid [2];
  logic             out_ready [2];
  logic [OUT_W-1:0] out_data  [2];
  logic [NB_W-1:0]  out_nbits [2];
  logic             out_last  [2];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  bit_packer #(.IN_W(IN_W), .OUT_W(OUT_W), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]),
    .in_len(in_len[0]), .in_last(in_last[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(out_data[0]),
    .out_nbits(out_nbits[0]), .out_last(out_last[0])
  );

  bit_packer #(.IN_W(IN_W), .OUT_W(OUT_W), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]),
    .in_len(in_len[1]), .in_last(in_last[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(out_data[1]),
    .out_nbits(out_nbits[1]), .out_last(out_last[1])
  );

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  // Model: each instance's stream is a bit array in arrival order; words are cut from its head.
  logic [63:0] sbits [2];
  int          scnt  [2];
  word_t exp_q0[$], exp_q1[$], got_q0[$], got_q1[$];

  function automatic void push_exp(int i, word_t w);
    if (i == 0) exp_q0.push_back(w);
    else exp_q1.push_back(w);
  endfunction

  function automatic word_t take_bits(int i, int n, logic lst);
    word_t w;
    w.data = '0;
    for (int p = 0; p < n; p++) begin
      if (i == 0) w.data[p] = sbits[i][p];
      else w.data[OUT_W-1-p] = sbits[i][p];
    end
    w.nbits  = NB_W'(n);
    w.last   = lst;
    sbits[i] = sbits[i] >> n;
    scnt[i]  = scnt[i] - n;
    return w;
  endfunction

  function automatic void model_accept(int i, logic [IN_W-1:0] d, int len, logic lst);
    int l;
    l = (len > IN_W) ? IN_W : len;
    for (int k = 0; k < l; k++) begin
      sbits[i][scnt[i]+k] = (i == 0) ? d[k] : d[l-1-k];
    end
    scnt[i] = scnt[i] + l;
    while (scnt[i] >= OUT_W) push_exp(i, take_bits(i, OUT_W, lst && (scnt[i] == OUT_W)));
    if (lst && scnt[i] > 0) push_exp(i, take_bits(i, scnt[i], 1'b1));
  endfunction

  // Compare process: mid-cycle, follow accepts into the model and check every emitted word.
  logic  held   [2];
  word_t held_w [2];
  initial begin
    word_t cur;
    word_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_q0.delete();
        exp_q1.delete();
        for (int i = 0; i < 2; i++) begin
          sbits[i] = '0;
          scnt[i]  = 0;
          held[i]  = 1'b0;
        end
      end else begin
        for (int i = 0; i < 2; i++) begin
          cur = {out_data[i], out_nbits[i], out_last[i]};
          if (in_valid[i] && in_ready[i]) model_accept(i, in_data[i], int'(in_len[i]), in_last[i]);
          if (out_valid[i]) chk($sformatf("mutex%0d", i), 32'(in_ready[i]), 32'd0);
          if (held[i]) begin
            chk($sformatf("hold_valid%0d", i), 32'(out_valid[i]), 32'd1);
            chk($sformatf("hold_word%0d", i), 32'(cur), 32'(held_w[i]));
          end
          if (out_valid[i] && out_ready[i]) begin
            if (i == 0) got_q0.push_back(cur);
            else got_q1.push_back(cur);
            if (((i == 0) ? exp_q0.size() : exp_q1.size()) == 0) begin
              checks++;
              failures++;
              $display("FAIL unexpected_word%0d: got 0x%0h, model required no word", i, cur);
            end else begin
              if (i == 0) e = exp_q0.pop_front();
              else e = exp_q1.pop_front();
              chk($sformatf("model_word%0d", i), 32'(cur), 32'(e));
            end
          end
          held[i]   = out_valid[i] && !out_ready[i];
          held_w[i] = cur;
        end
      end
    end
  end

  task automatic send(int i, logic [IN_W-1:0] d, int len, logic lst);
    int t;
    in_valid[i] = 1'b1;
    in_data[i]  = d;
    in_len[i]   = LEN_W'(len);
    in_last[i]  = lst;
    t = 0;
    @(negedge clk);
    while (!in_ready[i] && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready[i]) begin
      checks++;
      failures++;
      $display("FAIL send_timeout%0d: in_ready got 0 required 1", i);
    end
    @(posedge clk);
    #1;
    in_valid[i] = 1'b0;
    in_data[i]  = '0;
    in_len[i]   = '0;
    in_last[i]  = 1'b0;
  endtask

  task automatic expect_word(int i, string name, logic [OUT_W-1:0] d, int nb, logic lst);
    word_t g;
    int t;
    t = 0;
    while (((i == 0) ? got_q0.size() : got_q1.size()) == 0 && t < 100) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (((i == 0) ? got_q0.size() : got_q1.size()) == 0) begin
      checks++;
      failures++;
      $display("FAIL %s: no word seen, required data 0x%0h", name, d);
    end else begin
      if (i == 0) g = got_q0.pop_front();
      else g = got_q1.pop_front();
      chk({name, "_data"}, 32'(g.data), 32'(d));
      chk({name, "_nbits"}, 32'(g.nbits), 32'(nb));
      chk({name, "_last"}, 32'(g.last), 32'(lst));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 2; i++) begin
      in_valid[i]  = 1'b0;
      in_data[i]   = '0;
      in_len[i]    = '0;
      in_last[i]   = 1'b0;
      out_ready[i] = 1'b1;
    end
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("rst_out_valid", 32'(out_valid[i]), 32'd0);
      chk("rst_out_data", 32'(out_data[i]), 32'd0);
      chk("rst_out_nbits", 32'(out_nbits[i]), 32'd0);
      chk("rst_out_last", 32'(out_last[i]), 32'd0);
      chk("rst_in_ready", 32'(in_ready[i]), 32'd1);
    end
    @(posedge clk);
    #1;

    // Two whole bytes; the word must appear the cycle after the completing accept.
    send(0, 8'hA5, 8, 1'b0);
    send(0, 8'h3C, 8, 1'b1);
    chk("lat_out_valid", 32'(out_valid[0]), 32'd1);
    chk("pend_in_ready", 32'(in_ready[0]), 32'd0);
    expect_word(0, "two_full", 16'h3CA5, 16, 1'b1);

    send(0, 8'h05, 3, 1'b0);
    send(0, 8'h19, 5, 1'b0);
    send(0, 8'hFF, 8, 1'b0);
    expect_word(0, "var_full", 16'hFFCD, 16, 1'b0);
    send(0, 8'h06, 4, 1'b1);
    expect_word(0, "var_part", 16'h0006, 4, 1'b1);

    send(0, 8'hFF, 8, 1'b0);
    send(0, 8'h07, 4, 1'b0);
    send(0, 8'h5A, 8, 1'b1);
    expect_word(0, "straddle_full", 16'hA7FF, 16, 1'b0);
    expect_word(0, "straddle_part", 16'h0005, 4, 1'b1);

    // Over-long length is clamped to IN_W.
    send(0, 8'hC3, 15, 1'b0);
    send(0, 8'h81, 8, 1'b1);
    expect_word(0, "clamp", 16'h81C3, 16, 1'b1);

    out_ready[0] = 1'b0;
    send(0, 8'h5A, 8, 1'b0);
    send(0, 8'h96, 8, 1'b1);
    repeat (5) begin
      @(negedge clk);
      chk("bp_out_valid", 32'(out_valid[0]), 32'd1);
      chk("bp_in_ready", 32'(in_ready[0]), 32'd0);
      chk("bp_out_data", 32'(out_data[0]), 32'h965A);
    end
    @(posedge clk);
    #1;
    out_ready[0] = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_consumed", 32'(out_valid[0]), 32'd0);
    expect_word(0, "bp", 16'h965A, 16, 1'b1);

    // Zero-length last field on an empty packer: no word, input blocked one cycle.
    send(0, 8'hFF, 0, 1'b1);
    chk("zero_flush_busy", 32'(in_ready[0]), 32'd0);
    repeat (4) begin
      @(negedge clk);
      chk("zero_flush_valid", 32'(out_valid[0]), 32'd0);
    end
    chk("zero_flush_ready", 32'(in_ready[0]), 32'd1);
    chk("zero_flush_words", 32'(got_q0.size()), 32'd0);
    @(posedge clk);
    #1;
    send(0, 8'h12, 8, 1'b1);
    expect_word(0, "after_zero", 16'h0012, 8, 1'b1);

    // Reset with 12 bits buffered discards them.
    send(0, 8'hFF, 8, 1'b0);
    send(0, 8'h0F, 4, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_out_valid", 32'(out_valid[0]), 32'd0);
    chk("midrst_in_ready", 32'(in_ready[0]), 32'd1);
    @(posedge clk);
    #1;
    send(0, 8'h12, 8, 1'b0);
    send(0, 8'h34, 8, 1'b1);
    expect_word(0, "post_rst", 16'h3412, 16, 1'b1);

    send(1, 8'hA5, 8, 1'b0);
    send(1, 8'h3C, 8, 1'b1);
    expect_word(1, "msb_full", 16'hA53C, 16, 1'b1);
    send(1, 8'h05, 3, 1'b1);
    expect_word(1, "msb_part", 16'hA000, 3, 1'b1);
    send(1, 8'hFF, 8, 1'b0);
    send(1, 8'h07, 4, 1'b0);
    send(1, 8'h5A, 8, 1'b1);
    expect_word(1, "msb_straddle_full", 16'hFF75, 16, 1'b0);
    expect_word(1, "msb_straddle_part", 16'hA000, 4, 1'b1);

    repeat (5) @(posedge clk);
    #1;
    chk("exp_drained0", 32'(exp_q0.size()), 32'd0);
    chk("exp_drained1", 32'(exp_q1.size()), 32'd0);
    chk("got_drained0", 32'(got_q0.size()), 32'd0);
    chk("got_drained1", 32'(got_q1.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bit_packer.md
Name: bit_packer

Overview:
- Parametrised, registered successor to the team's fixed bit-slice concatenation logic.
- Packs a stream of variable-length bit fields, each 0..IN_W bits, into fixed OUT_W-bit words. Fields may straddle word boundaries.
- Input and output both use valid/ready handshakes.
- A packet-end flag flushes any partial word.
- Sits between field-producing encoders and word-wide buses or memories.

Parameters:
- IN_W, 8: maximum field width in bits. Must satisfy IN_W <= OUT_W.
- OUT_W, 16: output word width in bits.
- MSB_FIRST, 0: 0 places the first bit at out_data[0] (LSB-first); 1 places the first bit at out_data[OUT_W-1].

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  field present.
- in_ready  out  1  field accepted when in_valid && in_ready.
- in_data  in  IN_W  field bits; only in_data[in_len-1:0] are used.
- in_len  in  $clog2(IN_W+1)  field length; values > IN_W are clamped to IN_W.
- in_last  in  1  field is the last of its packet; flush after appending.
- out_valid  out  1  word present.
- out_ready  in  1  word consumed when out_valid && out_ready.
- out_data  out  OUT_W  packed word.
- out_nbits  out  $clog2(OUT_W+1)  number of valid bits in out_data (OUT_W except on a partial flush word).
- out_last  out  1  final word of the packet.

Behaviour:
- Reset: synchronous, active-high. The block already has one clock, clk, and the reset rst is synchronous and active-high.
- Reset values: in_ready=1 (after the reset cycle), out_valid=0, out_data=0, out_nbits=0, out_last=0. Internal state cleared: acc=0, fill=0, flush_pend=0.
- State:
  - acc: OUT_W+IN_W-1 bits.
  - fill: 0..OUT_W+IN_W-1.
  - flush_pend: 1 bit.
- in_ready = (fill < OUT_W) && !flush_pend.
- Accept, LSB-first:
  - acc[fill +: len] <= in_data[len-1:0], where len = clamped in_len.
  - fill <= fill + len.
  - If in_last: flush_pend <= 1.
  - in_len=0 is accepted and appends nothing.
- Accept, MSB_FIRST=1: field bit in_data[len-1] is placed first in stream order. Stream position p maps to word bit OUT_W-1-p.
- out_valid = (fill >= OUT_W) || (flush_pend && fill > 0). It is registered/derived from state only, never combinationally from in_valid.
- Full word (fill >= OUT_W):
  - out_data = the first OUT_W stream bits; out_nbits = OUT_W.
  - out_last = flush_pend && (fill == OUT_W).
- Partial word (flush_pend, 0 < fill < OUT_W):
  - out_nbits = fill; out_last = 1.
  - Unused bit positions are driven 0: high bits for LSB-first, low bits for MSB_FIRST.
- Output handshake: remove min(fill, OUT_W) bits from the stream head. The remaining bits shift to the head.
  - If the word had out_last: flush_pend <= 0.
- Flush with zero bits: if flush_pend && fill==0, no word is emitted and flush_pend clears on the next cycle.
- Mutual exclusion: in_ready and out_valid are never both 1. Accept and emit therefore cannot happen in the same cycle.
- Throughput: a full word blocks input until it is consumed. Peak rate is one field per cycle between word emissions.
- Backpressure: while out_valid && !out_ready, out_data/out_nbits/out_last hold stable and in_ready stays 0.
- Reset mid-packet: all buffered bits and flush_pend are discarded. No output is produced from the old packet after rst.
- Latency: a word that completes on accept is presented with out_valid the next cycle.

Test Plan:
- LSB-first, IN_W=8, OUT_W=16: fields 0xA5 (len 8), 0x3C (len 8, last) -> one word 0x3CA5, nbits=16, last=1; in_ready=0 while it is pending.
- Variable lengths: 0b101 (len 3), 0b11001 (len 5), 0xFF (len 8) -> 0xFFCD, last=0. Then 0x6 (len 4, last) -> 0x0006, nbits=4, last=1.
- Straddle: 0xFF (len 8), 0x7 (len 4), 0x5A (len 8, last) -> 0xA7FF, last=0; then 0x0005, nbits=4, last=1.
- Backpressure: hold out_ready=0 for 5 cycles with a full word pending -> out_data stable and in_ready=0 throughout; word consumed on the first cycle out_ready=1.
- MSB_FIRST=1: 0xA5, 0x3C (last) -> 0xA53C. Single 3-bit field 0b101 (last) -> 0xA000, nbits=3.
- Edge/reset: len-0 field with in_last and fill=0 -> no word emitted. rst asserted with fill=12 -> out_valid=0 next cycle, and the next packet 0x12, 0x34 (last) -> 0x3412.
